// File: rtl/dm_cache_ctrl_pkg.sv
// mem_pkg: shared FSM states, mode encodings and default geometry for dm_cache_ctrl.
package mem_pkg;
  localparam int D_RAM_DEPTH = 4096;
  localparam int D_CACHE_LINES = 64;
  localparam int D_RAM_LAT = 4;
  localparam int IDX_W = $clog2(D_RAM_DEPTH);
  localparam int LINE_W = $clog2(D_CACHE_LINES);
  localparam int TAG_W = IDX_W - LINE_W;
  localparam logic MODE_WR = 1'b1;
  localparam logic MODE_RD = 1'b0;
  typedef enum logic [1:0] {IDLE, LOOKUP, RAM_WAIT, RESP} state_t;
endpackage

// File: rtl/dm_cache_ctrl_if.sv
// dm_cache_ctrl_if: request/response bus between an access initiator and dm_cache_ctrl.
interface dm_cache_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        mode;
  logic [31:0] address;
  logic [31:0] data;
  logic        resp_valid;
  logic [31:0] out;
  logic        hit;
  modport master(output req_valid, mode, address, data, input req_ready, resp_valid, out, hit);
  modport slave(input req_valid, mode, address, data, output req_ready, resp_valid, out, hit);
endinterface

// File: rtl/dm_cache_ctrl_ram_sp.sv
// ram_sp: single-port backing RAM; the controller's counter supplies the access latency.
module ram_sp #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     i_re,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-through/write-allocate cache controller with valid/ready front end.
module dm_cache_ctrl
  import mem_pkg::*;
#(
  parameter int RAM_DEPTH = D_RAM_DEPTH,
  parameter int CACHE_LINES = D_CACHE_LINES,
  parameter int RAM_LAT = D_RAM_LAT
) (
  input logic clk,
  input logic rst,
  dm_cache_ctrl_if.slave bus
);
  localparam int IW = $clog2(RAM_DEPTH);
  localparam int LW = $clog2(CACHE_LINES);
  localparam int TW = IW - LW;
  localparam int CW = RAM_LAT > 1 ? $clog2(RAM_LAT) : 1;
  state_t           r_state;
  logic             r_mode;
  logic [IW-1:0]    r_idx;
  logic [31:0]      r_wdata;
  logic [CW-1:0]    r_cnt;
  logic [CACHE_LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag [CACHE_LINES];
  logic [31:0]      r_data [CACHE_LINES];
  logic [31:0]      r_out;
  logic             r_hit;
  logic [31:0]      w_rdata;
  logic [LW-1:0]    w_line;
  logic [TW-1:0]    w_tag;
  logic             w_match;
  logic             w_commit;
  logic [31:0]      w_fill;
  assign w_line = r_idx[LW-1:0];
  assign w_tag = r_idx[IW-1:LW];
  assign w_match = r_valid[w_line] && r_tag[w_line] == w_tag;
  // reset wins over the commit edge so an aborted write never reaches RAM or cache
  assign w_commit = r_state == RAM_WAIT && r_cnt == '0 && !rst;
  assign w_fill = r_mode == MODE_WR ? r_wdata : w_rdata;
  ram_sp #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk(clk),
    .i_re(r_state == LOOKUP),
    .i_we(w_commit && r_mode == MODE_WR),
    .i_addr(r_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_out <= '0;
      r_hit <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_state <= LOOKUP;
          r_mode <= bus.mode;
          r_idx <= bus.address[IW-1:0];
          r_wdata <= bus.data;
        end
        LOOKUP: if (r_mode == MODE_RD && w_match) begin
          r_state <= RESP;
          r_out <= r_data[w_line];
          r_hit <= 1'b1;
        end else begin
          r_state <= RAM_WAIT;
          r_cnt <= CW'(RAM_LAT - 1);
        end
        RAM_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        else begin
          r_state <= RESP;
          r_valid[w_line] <= 1'b1;
          r_tag[w_line] <= w_tag;
          r_data[w_line] <= w_fill;
          r_out <= w_fill;
          r_hit <= r_mode == MODE_WR && w_match;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = r_state == IDLE;
  assign bus.resp_valid = r_state == RESP;
  assign bus.out = r_out;
  assign bus.hit = r_hit;
endmodule
